acp_audio_dac: RTL

Output stage directly downstream of the acp audio copper. It takes the 8-bit samples acp produces through a valid/ready handshake and buffers them in a small FIFO. It releases them at a fixed sample rate derived from clk, and converts each to a 1-bit PWM (or sigma-delta) audio pin. It isolates acp's bursty bus-driven timing from the constant-rate analog output.

---
 rtl/acp_pkg.sv | 11 +
 rtl/acp_sample_fifo.sv | 57 +++++
 rtl/acp_audio_dac.sv | 127 ++++++++++++
 3 files changed

// File: rtl/acp_pkg.sv
// Shared types and defaults for the acp audio path (copper and DAC output stage).
package acp_pkg;

   typedef enum logic [1:0] {IDLE, PRIME, RUN} acp_state_t;

   localparam int         ACP_SAMPLE_W   = 8;
   localparam int         ACP_FIFO_DEPTH = 16;
   localparam int         ACP_SAMPLE_DIV = 1134;
   localparam logic [7:0] ACP_SAMPLE_MID = 8'h80;

endpackage

// File: rtl/acp_sample_fifo.sv
// Synchronous sample FIFO with flush; occupancy carries one extra bit so full is level == DEPTH.
module acp_sample_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            level <= level + LVL_ONE;
         else if (!do_push && do_pop)
            level <= level - LVL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/acp_audio_dac.sv
// acp audio output stage: sample FIFO, fixed-rate sample release and 1-bit PWM output.
// Define ACP_DAC_SIGMA_DELTA_EN to replace the PWM comparator with a first-order sigma-delta.
//
// state | meaning
// IDLE  | disabled: FIFO flushed, counters held, output silent, underrun cleared
// PRIME | filling: pushes accepted, PWM running, no sample ticks yet
// RUN   | streaming: one pop per tick, underrun latches on an empty tick
module acp_audio_dac
   import acp_pkg::*;
#(
   parameter int SAMPLE_W   = ACP_SAMPLE_W,
   parameter int FIFO_DEPTH = ACP_FIFO_DEPTH,
   parameter int SAMPLE_DIV = ACP_SAMPLE_DIV
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [SAMPLE_W-1:0]         sample_in,
   input  logic                        sample_valid,
   output logic                        sample_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        sample_tick,
   output logic                        underrun,
   output logic                        pwm_out
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(SAMPLE_DIV);

   localparam logic [TW-1:0]       TICK_LAST  = TW'(SAMPLE_DIV - 1);
   localparam logic [LW-1:0]       PRIME_LVL  = LW'(FIFO_DEPTH / 2);
   localparam logic [SAMPLE_W-1:0] SAMPLE_MID = (SAMPLE_W == 8) ? SAMPLE_W'(ACP_SAMPLE_MID)
                                                                : {1'b1, {(SAMPLE_W-1){1'b0}}};

   acp_state_t          state;
   logic [TW-1:0]       tick_cnt;
   logic [SAMPLE_W-1:0] pwm_cnt;
   logic [SAMPLE_W-1:0] cur_sample;
   logic [SAMPLE_W-1:0] duty;
   logic [SAMPLE_W-1:0] fifo_dout;
   logic                fifo_full;
   logic                fifo_empty;
   logic                active;
   logic                push;
   logic                pop;

`ifdef ACP_DAC_SIGMA_DELTA_EN
   logic [SAMPLE_W:0]   sd_acc;
   assign pwm_out = sd_acc[SAMPLE_W];
`else
   logic                pwm_q;
   assign pwm_out = pwm_q;
`endif

   // Dropping enable behaves like IDLE from this cycle on, so it lands on the very next edge.
   assign active       = enable && (state != IDLE);
   assign sample_ready = active && !fifo_full;
   assign push         = sample_valid && sample_ready;
   assign sample_tick  = (state == RUN) && (tick_cnt == TICK_LAST);
   assign pop          = sample_tick && !fifo_empty;

   acp_sample_fifo #(
      .W     (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (!active),
      .push  (push),
      .pop   (pop),
      .din   (sample_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         pwm_cnt    <= '0;
         cur_sample <= SAMPLE_MID;
         duty       <= SAMPLE_MID;
         underrun   <= 1'b0;
`ifdef ACP_DAC_SIGMA_DELTA_EN
         sd_acc     <= '0;
`else
         pwm_q      <= 1'b0;
`endif
      end else if (!active) begin
         state      <= enable ? PRIME : IDLE;
         tick_cnt   <= '0;
         pwm_cnt    <= '0;
         cur_sample <= SAMPLE_MID;
         duty       <= SAMPLE_MID;
         underrun   <= 1'b0;
`ifdef ACP_DAC_SIGMA_DELTA_EN
         sd_acc     <= '0;
`else
         pwm_q      <= 1'b0;
`endif
      end else begin
         pwm_cnt <= pwm_cnt + SAMPLE_W'(1);
         // Duty only changes at the period wrap so no PWM period is ever cut short.
         if (&pwm_cnt) duty <= cur_sample;

         case (state)
            PRIME:   if (fifo_level >= PRIME_LVL) state <= RUN;
            RUN:     tick_cnt <= sample_tick ? '0 : tick_cnt + TW'(1);
            default: state <= IDLE;
         endcase

         if (sample_tick) begin
            if (!fifo_empty) cur_sample <= fifo_dout;
            else             underrun   <= 1'b1;
         end

`ifdef ACP_DAC_SIGMA_DELTA_EN
         sd_acc <= {1'b0, sd_acc[SAMPLE_W-1:0]} + {1'b0, duty};
`else
         pwm_q  <= (pwm_cnt < duty);
`endif
      end
   end

endmodule
